// File: rtl/eespfal_dualrail_pipe.sv
// Cycle-level model of a WIDTH-bit, STAGES-deep EESPFAL dual-rail gate pipeline
// driven by a four-phase adiabatic power clock, with rail-code error tracking.
module eespfal_dualrail_pipe #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned STAGES    = 4,
   parameter int unsigned PHASE_LEN = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Dis,
   input  logic             MODE,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] A_bar,
   input  logic             ERR_CLR,
   output logic             IN_ACK,
   output logic [WIDTH-1:0] OUT,
   output logic [WIDTH-1:0] OUT_bar,
   output logic             VALID,
   output logic [1:0]       PHASE,
   output logic             ERR,
   output logic [7:0]       ERR_CNT
);

   localparam int unsigned CNT_W  = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
   localparam int unsigned NERR_W = $clog2(STAGES + 1);

   logic [CNT_W-1:0]              cnt;
   logic [1:0]                    gp;
   logic                          at_edge;
   logic                          wrap;

   logic [STAGES-1:0][WIDTH-1:0]  rail_t;
   logic [STAGES-1:0][WIDTH-1:0]  rail_f;
   logic [STAGES-1:0][WIDTH-1:0]  nxt_t;
   logic [STAGES-1:0][WIDTH-1:0]  nxt_f;
   logic [STAGES-1:0][WIDTH-1:0]  src_t;
   logic [STAGES-1:0][WIDTH-1:0]  src_f;
   logic [STAGES-1:0]             bad;
   logic [NERR_W-1:0]             n_err;

   logic [7:0]                    cnt_base;
   logic [8:0]                    cnt_sum;
   logic [7:0]                    err_cnt_nxt;
   logic                          err_nxt;

   assign at_edge = (cnt == '0);
   assign wrap    = (cnt == CNT_W'(PHASE_LEN - 1));

   // Free-running phase timer and global phase index
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt <= '0;
         gp  <= '0;
      end else if (wrap) begin
         cnt <= '0;
         gp  <= gp + 2'd1;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Per-stage evaluate / recover / discharge with rail-code checking
   always_comb begin
      logic [1:0] ps;
      ps    = '0;
      nxt_t = rail_t;
      nxt_f = rail_f;
      bad   = '0;
      n_err = '0;
      src_t = '0;
      src_f = '0;

      src_t[0] = A;
      src_f[0] = A_bar;
      for (int s = 1; s < int'(STAGES); s++) begin
         src_t[s] = rail_t[s-1];
         src_f[s] = rail_f[s-1];
      end

      for (int s = 0; s < int'(STAGES); s++) begin
         ps = gp - 2'(s);
         if (Dis) begin
            nxt_t[s] = '0;
            nxt_f[s] = '0;
         end else if (at_edge && ps == 2'd0) begin
            // Equal rails on any bit (null or 11) poison the whole word
            if (|(~(src_t[s] ^ src_f[s]))) begin
               bad[s]   = 1'b1;
               nxt_t[s] = '0;
               nxt_f[s] = '0;
            end else if (MODE) begin
               nxt_t[s] = src_f[s];
               nxt_f[s] = src_t[s];
            end else begin
               nxt_t[s] = src_t[s];
               nxt_f[s] = src_f[s];
            end
         end else if (at_edge && ps == 2'd2) begin
            nxt_t[s] = '0;
            nxt_f[s] = '0;
         end
      end

      for (int s = 0; s < int'(STAGES); s++) begin
         n_err = n_err + NERR_W'(bad[s]);
      end
   end

   // Saturating error count; a same-cycle error overrides the clear
   always_comb begin
      cnt_base    = ERR_CLR ? 8'd0 : ERR_CNT;
      cnt_sum     = 9'(cnt_base) + 9'(n_err);
      err_cnt_nxt = (cnt_sum > 9'd255) ? 8'd255 : cnt_sum[7:0];
      err_nxt     = (n_err != '0) | (ERR & ~ERR_CLR);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rail_t  <= '0;
         rail_f  <= '0;
         ERR     <= 1'b0;
         ERR_CNT <= 8'd0;
      end else begin
         rail_t  <= nxt_t;
         rail_f  <= nxt_f;
         ERR     <= err_nxt;
         ERR_CNT <= err_cnt_nxt;
      end
   end

   assign IN_ACK  = ~RST & ~Dis & at_edge & (gp == 2'd0);
   assign OUT     = rail_t[STAGES-1];
   assign OUT_bar = rail_f[STAGES-1];
   assign VALID   = &(rail_t[STAGES-1] ^ rail_f[STAGES-1]);
   assign PHASE   = gp;

endmodule

// File: tb/tb_eespfal_dualrail_pipe.sv
// Bench for eespfal_dualrail_pipe: a 4-stage and a 3-stage instance share stimulus,
// expected words are queued at sample time and compared when due at the outputs.
module tb_eespfal_dualrail_pipe;

   localparam int W = 4;

   logic         CLK = 1'b0;
   logic         RST, Dis, MODE, ERR_CLR;
   logic [W-1:0] A, A_bar;

   logic         in_ack4, valid4, err4;
   logic [W-1:0] out4, outb4;
   logic [1:0]   phase4;
   logic [7:0]   errcnt4;

   logic         in_ack3, valid3, err3;
   logic [W-1:0] out3, outb3;
   logic [1:0]   phase3;
   logic [7:0]   errcnt3;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [W-1:0] t;
      logic [W-1:0] f;
      int           due;
   } exp_t;

   exp_t q4[$];
   exp_t q3[$];

   always #5 CLK = ~CLK;

   eespfal_dualrail_pipe #(.WIDTH(W), .STAGES(4), .PHASE_LEN(2)) dut4 (
      .CLK(CLK), .RST(RST), .Dis(Dis), .MODE(MODE), .A(A), .A_bar(A_bar),
      .ERR_CLR(ERR_CLR), .IN_ACK(in_ack4), .OUT(out4), .OUT_bar(outb4),
      .VALID(valid4), .PHASE(phase4), .ERR(err4), .ERR_CNT(errcnt4)
   );

   eespfal_dualrail_pipe #(.WIDTH(W), .STAGES(3), .PHASE_LEN(2)) dut3 (
      .CLK(CLK), .RST(RST), .Dis(Dis), .MODE(MODE), .A(A), .A_bar(A_bar),
      .ERR_CLR(ERR_CLR), .IN_ACK(in_ack3), .OUT(out3), .OUT_bar(outb3),
      .VALID(valid3), .PHASE(phase3), .ERR(err3), .ERR_CNT(errcnt3)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Leaves the bench inside cycle 0: reset state, RST already low
   task automatic do_reset();
      RST = 1'b1;
      Dis = 1'b0;
      ERR_CLR = 1'b0;
      tick();
      tick();
      RST = 1'b0;
      q4.delete();
      q3.delete();
   endtask

   task automatic test_reset();
      RST = 1'b1; Dis = 1'b0; ERR_CLR = 1'b0; MODE = 1'b0;
      A = 4'b1010; A_bar = 4'b0101;
      tick();
      tick();
      #1;
      n_cmp++; if (out4 !== 4'b0 || outb4 !== 4'b0) begin n_bad++; $display("FAIL reset_out: got %b/%b expected 0000/0000", out4, outb4); end
      n_cmp++; if (valid4 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", valid4); end
      n_cmp++; if (phase4 !== 2'd0) begin n_bad++; $display("FAIL reset_phase: got %0d expected 0", phase4); end
      n_cmp++; if (err4 !== 1'b0 || errcnt4 !== 8'd0) begin n_bad++; $display("FAIL reset_err: got %b/%0d expected 0/0", err4, errcnt4); end
      n_cmp++; if (in_ack4 !== 1'b0) begin n_bad++; $display("FAIL reset_in_ack: got %b expected 0", in_ack4); end
      RST = 1'b0;
      #1;
      n_cmp++; if (in_ack4 !== 1'b1) begin n_bad++; $display("FAIL reset_first_sample: got %b expected 1", in_ack4); end
   endtask

   // Continuous word stream; each instance's output is checked every cycle
   task automatic test_flow(input logic [W-1:0] a, input logic [W-1:0] ab, input logic mode, input int ncyc);
      exp_t cur4, cur3, e;
      bit   have4, have3, act;
      logic [W-1:0] et, ef;
      have4 = 0; have3 = 0;
      do_reset();
      MODE = mode; A = a; A_bar = ab;
      for (int c = 0; c < ncyc; c++) begin
         if (c > 0) tick();
         #1;
         if (c % 8 == 0) begin
            e.t = a; e.f = ab; e.due = c + 7;
            q4.push_back(e);
            e.t = mode ? ab : a; e.f = mode ? a : ab; e.due = c + 5;
            q3.push_back(e);
         end
         n_cmp++; if (in_ack4 !== (c % 8 == 0)) begin n_bad++; $display("FAIL flow_in_ack4 c=%0d: got %b expected %b", c, in_ack4, (c % 8 == 0)); end
         n_cmp++; if (in_ack3 !== (c % 8 == 0)) begin n_bad++; $display("FAIL flow_in_ack3 c=%0d: got %b expected %b", c, in_ack3, (c % 8 == 0)); end

         if (q4.size() > 0 && q4[0].due == c) begin cur4 = q4.pop_front(); have4 = 1; end
         act = have4 && c >= cur4.due && c < cur4.due + 4;
         et = act ? cur4.t : 4'b0; ef = act ? cur4.f : 4'b0;
         n_cmp++; if (out4 !== et || outb4 !== ef || valid4 !== act) begin
            n_bad++; $display("FAIL flow_out4 c=%0d: got %b/%b v%b expected %b/%b v%b", c, out4, outb4, valid4, et, ef, act);
         end

         if (q3.size() > 0 && q3[0].due == c) begin cur3 = q3.pop_front(); have3 = 1; end
         act = have3 && c >= cur3.due && c < cur3.due + 4;
         et = act ? cur3.t : 4'b0; ef = act ? cur3.f : 4'b0;
         n_cmp++; if (out3 !== et || outb3 !== ef || valid3 !== act) begin
            n_bad++; $display("FAIL flow_out3 c=%0d: got %b/%b v%b expected %b/%b v%b", c, out3, outb3, valid3, et, ef, act);
         end
      end
   endtask

   task automatic test_bad_code();
      logic       exp_err;
      logic [7:0] exp_cnt;
      do_reset();
      MODE = 1'b1;
      for (int c = 0; c < 18; c++) begin
         if (c > 0) tick();
         A       = (c == 0 || c == 16) ? 4'b1110 : 4'b1010;
         A_bar   = 4'b0101;
         ERR_CLR = (c == 12 || c == 16);
         #1;
         if (c == 0) begin exp_err = 0; exp_cnt = 0; end
         else if (c <= 12) begin exp_err = 1; exp_cnt = 8'((c + 1) / 2 > 4 ? 4 : (c + 1) / 2); end
         else if (c <= 16) begin exp_err = 0; exp_cnt = 0; end
         else begin exp_err = 1; exp_cnt = 1; end
         n_cmp++; if (err4 !== exp_err || errcnt4 !== exp_cnt) begin
            n_bad++; $display("FAIL bad_err c=%0d: got %b/%0d expected %b/%0d", c, err4, errcnt4, exp_err, exp_cnt);
         end
         if (c <= 14) begin
            n_cmp++; if (valid4 !== 1'b0) begin n_bad++; $display("FAIL bad_valid c=%0d: got %b expected 0", c, valid4); end
         end
         if (c == 15) begin
            n_cmp++; if (out4 !== 4'b1010 || valid4 !== 1'b1) begin n_bad++; $display("FAIL bad_recover: got %b v%b expected 1010 v1", out4, valid4); end
         end
         if (c == 7) begin
            n_cmp++; if (err3 !== 1'b1 || errcnt3 !== 8'd3) begin n_bad++; $display("FAIL bad_err3: got %b/%0d expected 1/3", err3, errcnt3); end
         end
      end
      ERR_CLR = 1'b0;
   endtask

   task automatic test_discharge();
      do_reset();
      MODE = 1'b1; A = 4'b1010; A_bar = 4'b0101;
      for (int c = 0; c < 16; c++) begin
         if (c > 0) tick();
         Dis = (c < 8);
         #1;
         n_cmp++; if (in_ack4 !== (c == 8)) begin n_bad++; $display("FAIL dis_in_ack c=%0d: got %b expected %b", c, in_ack4, (c == 8)); end
         n_cmp++; if (errcnt4 !== 8'd0) begin n_bad++; $display("FAIL dis_errcnt c=%0d: got %0d expected 0", c, errcnt4); end
         if (c == 7) begin
            n_cmp++; if (out4 !== 4'b0 || valid4 !== 1'b0) begin n_bad++; $display("FAIL dis_no_word: got %b v%b expected 0000 v0", out4, valid4); end
         end
         if (c == 15) begin
            n_cmp++; if (out4 !== 4'b1010 || outb4 !== 4'b0101 || valid4 !== 1'b1) begin
               n_bad++; $display("FAIL dis_after: got %b/%b v%b expected 1010/0101 v1", out4, outb4, valid4);
            end
         end
      end
      Dis = 1'b0;
   endtask

   task automatic test_reset_midflight();
      exp_t e;
      do_reset();
      MODE = 1'b0; A = 4'b1010; A_bar = 4'b0101;
      for (int c = 0; c < 14; c++) begin
         if (c > 0) tick();
         RST = (c == 4);
         if (c == 4) begin A = 4'b0110; A_bar = 4'b1001; end
         #1;
         if (c == 4) begin
            n_cmp++; if (in_ack4 !== 1'b0) begin n_bad++; $display("FAIL mid_in_ack_rst: got %b expected 0", in_ack4); end
         end
         if (c == 5) begin
            e.t = A; e.f = A_bar; e.due = c + 7;
            q4.push_back(e);
            n_cmp++; if (phase4 !== 2'd0 || in_ack4 !== 1'b1) begin n_bad++; $display("FAIL mid_restart: got ph%0d ack%b expected ph0 ack1", phase4, in_ack4); end
         end
         if (c >= 5 && c <= 11) begin
            n_cmp++; if (out4 !== 4'b0 || outb4 !== 4'b0 || valid4 !== 1'b0) begin
               n_bad++; $display("FAIL mid_flushed c=%0d: got %b/%b v%b expected 0000/0000 v0", c, out4, outb4, valid4);
            end
         end
         if (c == 12) begin
            if (q4.size() == 0) begin
               n_cmp++; n_bad++; $display("FAIL mid_queue: got empty expected one word");
            end else begin
               e = q4.pop_front();
               n_cmp++; if (out4 !== e.t || outb4 !== e.f || valid4 !== 1'b1) begin
                  n_bad++; $display("FAIL mid_new_word: got %b/%b v%b expected %b/%b v1", out4, outb4, valid4, e.t, e.f);
               end
            end
         end
      end
      RST = 1'b0;
   endtask

   task automatic test_saturation();
      logic [1:0] exp_ph;
      do_reset();
      MODE = 1'b0; A = 4'b0; A_bar = 4'b0;
      for (int c = 0; c < 2400; c++) begin
         if (c > 0) tick();
         #1;
         exp_ph = 2'((c / 2) % 4);
         n_cmp++; if (phase4 !== exp_ph || phase3 !== exp_ph) begin
            n_bad++; $display("FAIL sat_phase c=%0d: got %0d/%0d expected %0d", c, phase4, phase3, exp_ph);
         end
         if (c == 1) begin
            n_cmp++; if (errcnt4 !== 8'd1) begin n_bad++; $display("FAIL sat_first: got %0d expected 1", errcnt4); end
         end
         if (c == 1000 || c == 2399) begin
            n_cmp++; if (errcnt4 !== 8'd255 || err4 !== 1'b1) begin n_bad++; $display("FAIL sat_count c=%0d: got %0d/%b expected 255/1", c, errcnt4, err4); end
         end
      end
   endtask

   initial begin
      RST = 1'b1; Dis = 1'b0; MODE = 1'b0; ERR_CLR = 1'b0;
      A = '0; A_bar = '0;
      test_reset();
      test_flow(4'b1010, 4'b0101, 1'b1, 20);
      test_flow(4'b1010, 4'b0101, 1'b0, 20);
      test_flow(4'b0011, 4'b1100, 1'b1, 28);
      test_bad_code();
      test_discharge();
      test_reset_midflight();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
